charlieplex_scanner: RTL and testbench

//  Time-multiplexing scheduler for a charlieplexer: walks all pixels, drives the
//  LED index and enable, and applies per-pixel PWM brightness with blanking
//  (dead time) between pixels to suppress ghosting.

---
 rtl/charlieplex_scanner.sv | 169 ++++++++++++++++
 tb/tb_charlieplex_scanner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_scanner.sv
// Charlieplex pixel scanner: per-pixel PWM slot with dead time, double-buffered brightness banks.
// Optional build macro CHARLIEPLEX_SKIP_DARK_EN: dark pixels take a single cycle instead of a full slot.
//
// state | meaning
// IDLE  | display blanked, waiting for enable; pending swap executes here
// DEAD  | pixel selected, LED off (blanking before ON window)
// ON    | PWM window, LED lit for the first b cycles
module charlieplex_scanner #(
  parameter  int PIXELCOUNT = 12,
  parameter  int BRIGHTBITS = 4,
  parameter  int DEADTIME   = 2,
  localparam int IDXBITS    = $clog2(PIXELCOUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [IDXBITS-1:0]    wr_addr,
  input  logic [BRIGHTBITS-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output logic [IDXBITS-1:0]    led_index,
  output logic                  led_enable
);

  localparam int PW   = 2**BRIGHTBITS - 1;
  localparam int CNTW = (BRIGHTBITS > $clog2(DEADTIME+1)) ? BRIGHTBITS : $clog2(DEADTIME+1);

  typedef enum logic [1:0] {IDLE, DEAD, ON} state_e;

  state_e                state_q, state_d;
  logic [IDXBITS-1:0]    pix_q, pix_d, nxt_pix, ent_pix;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [BRIGHTBITS-1:0] bright_q, bright_d, cur_b;
  logic                  sel_q, sel_d, pend_q, pend_d, pend_now;
  logic                  enter, do_swap;
  logic [IDXBITS-1:0]    led_index_q, led_index_d;
  logic                  led_enable_q, led_enable_d;
  logic                  frame_start_q, frame_start_d;
  logic                  swap_ack_q, swap_ack_d;
  logic [BRIGHTBITS-1:0] bank_q [2][PIXELCOUNT];
`ifdef CHARLIEPLEX_SKIP_DARK_EN
  logic [BRIGHTBITS-1:0] nxt_b;
`endif

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    cnt_d         = cnt_q;
    bright_d      = bright_q;
    sel_d         = sel_q;
    pend_now      = pend_q | swap_req;
    pend_d        = pend_now;
    frame_start_d = 1'b0;
    swap_ack_d    = 1'b0;
    enter         = 1'b0;
    do_swap       = 1'b0;
    ent_pix       = '0;
    cur_b         = bank_q[sel_q][pix_q];
    nxt_pix       = (pix_q == IDXBITS'(PIXELCOUNT-1)) ? '0 : pix_q + IDXBITS'(1);

    if (!enable) begin
      state_d = IDLE;
      if (state_q == IDLE && pend_now) do_swap = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          enter   = 1'b1;
          ent_pix = '0;
        end
        DEAD: begin
          if (cnt_q == '0) begin
`ifdef CHARLIEPLEX_SKIP_DARK_EN
            if (cur_b == '0) begin
              enter   = 1'b1;
              ent_pix = nxt_pix;
            end else
`endif
            begin
              state_d  = ON;
              cnt_d    = CNTW'(PW-1);
              bright_d = cur_b;
            end
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        ON: begin
          if (cnt_q == '0) begin
            enter   = 1'b1;
            ent_pix = nxt_pix;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (enter) begin
      state_d = DEAD;
      pix_d   = ent_pix;
      cnt_d   = CNTW'(DEADTIME-1);
      if (ent_pix == '0) begin
        frame_start_d = 1'b1;
        if (pend_now) do_swap = 1'b1;
      end
    end

    if (do_swap) begin
      sel_d      = ~sel_q;
      swap_ack_d = 1'b1;
      pend_d     = 1'b0;
    end

`ifdef CHARLIEPLEX_SKIP_DARK_EN
    // Dark pixel on entry: single-cycle DEAD, then straight on to the next pixel.
    nxt_b = bank_q[sel_d][pix_d];
    if (enter && nxt_b == '0) cnt_d = '0;
`endif

    led_index_d  = pix_d;
    led_enable_d = (state_d == ON) && (int'(cnt_d) + int'(bright_d) >= PW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pix_q         <= '0;
      cnt_q         <= '0;
      bright_q      <= '0;
      sel_q         <= 1'b0;
      pend_q        <= 1'b0;
      led_index_q   <= '0;
      led_enable_q  <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      cnt_q         <= cnt_d;
      bright_q      <= bright_d;
      sel_q         <= sel_d;
      pend_q        <= pend_d;
      led_index_q   <= led_index_d;
      led_enable_q  <= led_enable_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  // Host writes land in the bank that is back at the time of the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < PIXELCOUNT; p++)
          bank_q[b][p] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < (IDXBITS+1)'(PIXELCOUNT))) begin
      bank_q[~sel_q][wr_addr] <= wr_data;
    end
  end

  assign led_index   = led_index_q;
  assign led_enable  = led_enable_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Bench for charlieplex_scanner: per-frame scoreboard (expected frames queued by stimulus,
// a monitor closes each observed frame at the next frame_start) plus direct output checks.
module tb_charlieplex_scanner;

  localparam int NPIX = 12;
`ifdef CHARLIEPLEX_SKIP_DARK_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic              ack;
    logic [3:0]        mid_ack;
    logic [7:0]        len;
    logic [11:0][3:0]  cyc;
    logic [11:0][3:0]  lit;
    logic [11:0][3:0]  first;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start, led_enable;
  logic [3:0] led_index;

  int     total = 0;
  int     bad = 0;
  int     nframe = 0;
  bit     abort = 1'b1;
  bit     in_frame = 1'b0;
  frame_t cur;
  frame_t exp_q[$];

  charlieplex_scanner #(.PIXELCOUNT(12), .BRIGHTBITS(2), .DEADTIME(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .led_index(led_index), .led_enable(led_enable)
  );

  always #5 clk = ~clk;

  // Hand-written brightness vector -> expected frame (slot 4 cycles, dark = 1 cycle when skipping).
  function automatic frame_t mk(input logic ack, input logic [11:0][1:0] br);
    frame_t f = '0;
    f.ack = ack;
    for (int p = 0; p < NPIX; p++) begin
      f.cyc[p]   = (SKIP && br[p] == 2'd0) ? 4'd1 : 4'd4;
      f.lit[p]   = {2'b00, br[p]};
      f.first[p] = (br[p] != 2'd0) ? 4'd1 : 4'hF;
      f.len      = f.len + {4'd0, f.cyc[p]};
    end
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic close_frame();
    frame_t e;
    nframe++;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL frame%0d unexpected got=%h", nframe, cur);
    end else begin
      e = exp_q.pop_front();
      if (cur !== e) begin
        bad++;
        $display("FAIL frame%0d got=%h want=%h", nframe, cur, e);
      end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst_n || abort) begin
      in_frame = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) close_frame();
        cur = '0;
        for (int p = 0; p < NPIX; p++) cur.first[p] = 4'hF;
        cur.ack  = swap_ack;
        in_frame = 1'b1;
      end else if (in_frame && swap_ack) begin
        cur.mid_ack = cur.mid_ack + 4'd1;
      end
      if (in_frame && led_index < 4'd12) begin
        if (led_enable) begin
          if (cur.lit[led_index] == 4'd0) cur.first[led_index] = cur.cyc[led_index];
          cur.lit[led_index] = cur.lit[led_index] + 4'd1;
        end
        cur.cyc[led_index] = cur.cyc[led_index] + 4'd1;
        cur.len = cur.len + 8'd1;
      end
    end
  end

  task automatic wait_q(input int n, input int budget, input string nm);
    int k = 0;
    while (exp_q.size() > n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (exp_q.size() > n) begin
      bad++;
      $display("FAIL %s timeout got=%0d want=%0d", nm, exp_q.size(), n);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    logic [11:0][1:0] b5_3, b5_1, b9, z, b3;
    int k;
    b5_3 = '0; b5_3[5] = 2'd3;
    b5_1 = '0; b5_1[5] = 2'd1;
    b9   = '0; b9[2] = 2'd3; b9[5] = 2'd3; b9[7] = 2'd3;
    z    = '0;
    b3   = '0; b3[3] = 2'd2;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_led_enable", led_enable, 0);
    chk("rst_led_index", led_index, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_swap_ack", swap_ack, 0);

    // px5=3, swap together with enable: ack on first frame_start
    wr(4'd5, 2'd3);
    exp_q.push_back(mk(1'b1, b5_3));
    exp_q.push_back(mk(1'b0, b5_3));
    swap_req = 1'b1; enable = 1'b1; abort = 1'b0;
    @(negedge clk);
    swap_req = 1'b0;
    wait_q(0, 200, "drain_px5_3");

    // px5=1 plus an out-of-range write, swapped in at the next boundary
    exp_q.push_back(mk(1'b0, b5_3));
    exp_q.push_back(mk(1'b1, b5_1));
    exp_q.push_back(mk(1'b0, b5_1));
    wr(4'd5, 2'd1);
    wr(4'd12, 2'd3);
    pulse_swap();
    wait_q(0, 250, "drain_px5_1");

    // px2/px7 written without swap stay invisible until swapped
    exp_q.push_back(mk(1'b0, b5_1));
    exp_q.push_back(mk(1'b0, b5_1));
    exp_q.push_back(mk(1'b0, b5_1));
    exp_q.push_back(mk(1'b1, b9));
    wr(4'd2, 2'd3);
    wr(4'd7, 2'd3);
    wait_q(2, 200, "reach_third_frame");
    pulse_swap();
    wait_q(0, 200, "drain_px2");

    // disable during px7 ON, swap while idle, re-enable
    k = 0;
    while (!(led_index == 4'd7 && led_enable) && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("px7_on_reached", (led_index == 4'd7 && led_enable), 1);
    enable = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("dis_led_enable", led_enable, 0);
    chk("dis_led_index", led_index, 7);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    chk("idle_swap_ack", swap_ack, 1);
    @(negedge clk);
    chk("idle_swap_ack_end", swap_ack, 0);
    chk("idle_led_index", led_index, 7);
    exp_q.push_back(mk(1'b0, b5_1));
    enable = 1'b1; abort = 1'b0;
    @(negedge clk);
    chk("reen_frame_start", frame_start, 1);
    chk("reen_led_index", led_index, 0);
    wait_q(0, 100, "drain_reenable");

    // reset in the middle of px5 ON window
    k = 0;
    while (!led_enable && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("lit_before_reset", led_enable, 1);
    abort = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_led_enable", led_enable, 0);
    chk("midrst_led_index", led_index, 0);
    chk("midrst_frame_start", frame_start, 0);
    chk("midrst_swap_ack", swap_ack, 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(1'b1, z));
    swap_req = 1'b1; enable = 1'b1; abort = 1'b0;
    @(negedge clk);
    swap_req = 1'b0;
    wait_q(0, 100, "drain_cleared");

    // single mid-brightness pixel (frame length 48, or 15 with dark skipping)
    exp_q.push_back(mk(1'b0, z));
    exp_q.push_back(mk(1'b1, b3));
    wr(4'd3, 2'd2);
    pulse_swap();
    wait_q(0, 200, "drain_px3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
